// File: rtl/alu_ctrl_pkg.sv
// Purpose: shared constants for the ALU input sequencer: button indices, loaded-mask width, ALU opcodes.
// Latency: none (constants only).
// Backpressure: none. Optional feature macro CTRL_DEBOUNCE_EN is consumed by button_conditioner.
package alu_ctrl_pkg;

  // Button positions inside i_pulsadores
  localparam int BTN_OP1 = 0;
  localparam int BTN_OP2 = 1;
  localparam int BTN_OPC = 2;
  localparam int BTN_CLR = 3;

  // Width of the {opcode, op_2, op_1} loaded mask
  localparam int LOADED_W = 3;

  // Opcodes understood by the alu core
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;

endpackage

// File: rtl/alu.sv
// Purpose: combinational signed ALU core; unknown opcodes produce zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6
) (
  input  logic signed [NB_DATA-1:0]   i_a,
  input  logic signed [NB_DATA-1:0]   i_b,
  input  logic        [NB_OPCODE-1:0] i_op,
  output logic signed [NB_DATA-1:0]   o_res
);

  // Operation select; shift amounts treat i_b as unsigned
  always_comb begin
    o_res = '0;
    case (i_op)
      NB_OPCODE'(OP_ADD): o_res = i_a + i_b;
      NB_OPCODE'(OP_SUB): o_res = i_a - i_b;
      NB_OPCODE'(OP_AND): o_res = i_a & i_b;
      NB_OPCODE'(OP_OR):  o_res = i_a | i_b;
      NB_OPCODE'(OP_XOR): o_res = i_a ^ i_b;
      NB_OPCODE'(OP_NOR): o_res = ~(i_a | i_b);
      NB_OPCODE'(OP_SRL): o_res = $signed($unsigned(i_a) >> $unsigned(i_b));
      NB_OPCODE'(OP_SRA): o_res = i_a >>> $unsigned(i_b);
      default:            o_res = '0;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Purpose: one pushbutton -> 2-FF synchroniser -> stable level (debounced when CTRL_DEBOUNCE_EN) -> rising-edge pulse.
// Latency: pulse visible 2 edges after the pin is sampled high, plus DEBOUNCE_CYCLES when CTRL_DEBOUNCE_EN is defined.
// Backpressure: none; a held button yields exactly one pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_stable;

  // A debounce window shorter than two samples cannot reject anything
  if (DEBOUNCE_CYCLES < 2) begin : g_illegal_debounce_cycles
  end

  // Synchroniser flops and previous stable level for edge detection
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_prev  <= w_stable;
    end
  end

`ifdef CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;

  // Stable level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_stable = r_stable;
`else
  assign w_stable = r_sync2;
`endif

  assign o_pulse = w_stable & ~r_prev;

endmodule

// File: rtl/alu_input_sequencer.sv
// Purpose: loads ALU operands/opcode from switches on single button pulses, rejects multi-presses, registers the ALU result. Macro: CTRL_DEBOUNCE_EN.
// Latency: pin -> register load 3 edges, -> o_result/o_valid 4 edges (add DEBOUNCE_CYCLES with CTRL_DEBOUNCE_EN).
// Backpressure: none; simultaneous presses are dropped and flagged on the sticky o_error.
module alu_input_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int NB_DATA         = 8,
  parameter int NB_OPCODE       = 6,
  parameter int N_PULSADORES    = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic signed [NB_DATA-1:0]  i_switches,
  input  logic [N_PULSADORES-1:0]    i_pulsadores,
  output logic signed [NB_DATA-1:0]  o_result,
  output logic                       o_valid,
  output logic [LOADED_W-1:0]        o_loaded,
  output logic                       o_error
);

  // Opcode must fit in the switch bank; only 3 or 4 buttons exist on the board
  if ((NB_OPCODE > NB_DATA) || (N_PULSADORES < 3) || (N_PULSADORES > 4)) begin : g_illegal_params
  end

  logic [N_PULSADORES-1:0]   w_pulse;
  logic [3:0]                w_pls;
  logic                      w_any;
  logic                      w_single;
  logic                      w_multi;
  logic signed [NB_DATA-1:0] w_alu;

  logic signed [NB_DATA-1:0] r_op1;
  logic signed [NB_DATA-1:0] r_op2;
  logic [NB_OPCODE-1:0]      r_opc;
  logic [LOADED_W-1:0]       r_loaded;
  logic                      r_error;
  logic                      r_load_d;
  logic signed [NB_DATA-1:0] r_result;
  logic                      r_valid;

  for (genvar k = 0; k < N_PULSADORES; k++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_pin   (i_pulsadores[k]),
      .o_pulse (w_pulse[k])
    );
  end

  // Pad the pulse vector to four bits so a 3-button build never sees a clear
  always_comb begin
    w_pls = '0;
    w_pls[N_PULSADORES-1:0] = w_pulse;
  end

  assign w_any    = |w_pls;
  assign w_single = w_any && ((w_pls & (w_pls - 4'd1)) == 4'd0);
  assign w_multi  = w_any && !w_single;

  alu #(
    .NB_DATA   (NB_DATA),
    .NB_OPCODE (NB_OPCODE)
  ) u_alu (
    .i_a   (r_op1),
    .i_b   (r_op2),
    .i_op  (r_opc),
    .o_res (w_alu)
  );

  // Load decode, soft clear, sticky error and registered result stage
  always_ff @(posedge i_clock) begin
    if (i_reset || (w_single && w_pls[BTN_CLR])) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_opc    <= '0;
      r_loaded <= '0;
      r_error  <= 1'b0;
      r_load_d <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid  <= &r_loaded;
      r_load_d <= 1'b0;
      if (r_load_d) begin
        r_result <= w_alu;
      end
      if (w_multi) begin
        r_error <= 1'b1;
      end else if (w_single) begin
        r_error  <= 1'b0;
        r_load_d <= 1'b1;
        if (w_pls[BTN_OP1]) begin
          r_op1              <= i_switches;
          r_loaded[BTN_OP1]  <= 1'b1;
        end
        if (w_pls[BTN_OP2]) begin
          r_op2              <= i_switches;
          r_loaded[BTN_OP2]  <= 1'b1;
        end
        if (w_pls[BTN_OPC]) begin
          r_opc              <= i_switches[NB_OPCODE-1:0];
          r_loaded[BTN_OPC]  <= 1'b1;
        end
      end
    end
  end

  assign o_result = r_result;
  assign o_valid  = r_valid;
  assign o_loaded = r_loaded;
  assign o_error  = r_error;

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Parametrised successor to the board-level ALU controller; sits between Basys3 switches/pushbuttons and the combinational `alu` core.
- Each button input is synchronised, optionally debounced, and turned into a single-cycle rising-edge pulse.
- Operand/opcode registers load only on those pulses; simultaneous presses are rejected and flagged.
- ALU output is registered, with a validity flag and a per-register loaded mask for LEDs.

Parameters:
- NB_DATA, 8, operand and result width (signed).
- NB_OPCODE, 6, opcode width; must be <= NB_DATA.
- N_PULSADORES, 4, button count; legal values 3 or 4; bit 3 (when present) is soft clear.
- DEBOUNCE_CYCLES, 100000, consecutive stable samples required when CTRL_DEBOUNCE_EN is defined; must be >= 2.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_switches  input  NB_DATA  signed data from switches.
- i_pulsadores  input  N_PULSADORES  raw asynchronous buttons: bit0 op_1, bit1 op_2, bit2 opcode, bit3 clear.
- o_result  output  NB_DATA  registered signed ALU result.
- o_valid  output  1  high when op_1, op_2 and opcode have all been loaded since last reset/clear.
- o_loaded  output  3  loaded mask {opcode, op_2, op_1}.
- o_error  output  1  sticky: a multi-button press was rejected.

Behaviour:
- Reset (sync, active-high, priority over everything):
  - op_1, op_2, opcode, o_result, o_loaded, o_error, o_valid <= 0.
  - Synchroniser, debounce and edge-detect state <= 0.
- Input path per button:
  - 2-FF synchroniser, then stable level, then edge detect.
  - pulse[k] = stable[k] & ~stable_prev[k]; high for exactly one cycle per press; held buttons do not retrigger.
- Latency, macro off: pin high before edge E1 -> pulse during cycle after E2 -> register loads at E3 -> o_result/o_valid update at E4.
- Latency, macro on: add DEBOUNCE_CYCLES cycles.
- Decode uses the pulse vector, not raw levels:
  - Exactly one pulse bit set: perform that action.
  - More than one set: no register changes, o_error <= 1.
  - Zero set: hold all registers.
- Actions:
  - bit0: op_1 <= i_switches; o_loaded[0] <= 1.
  - bit1: op_2 <= i_switches; o_loaded[1] <= 1.
  - bit2: opcode <= i_switches[NB_OPCODE-1:0] (upper switch bits ignored); o_loaded[2] <= 1.
  - bit3 (N_PULSADORES == 4): op_1, op_2, opcode, o_loaded, o_error, o_result <= 0.
- o_error is cleared by reset, soft clear, or the next accepted single load.
- Result stage:
  - One cycle after an accepted load, o_result <= alu(op_1, op_2, opcode).
  - Otherwise o_result holds its value; it does not track switch changes.
  - Update happens even if o_valid is 0; o_result is only meaningful when o_valid is 1.
- o_valid is registered and equals &o_loaded delayed one cycle, so it rises in the same cycle as the o_result that first uses all three values.
- Reset asserted mid-debounce or mid-press: counters clear. A button still held after reset deasserts produces one pulse once it is seen stable high, because edge state reset to 0.
- State summary for review: EMPTY (o_loaded == 0) -> PARTIAL -> READY (all set). Soft clear or reset returns to EMPTY from any state; no other backward transition.

Optional Feature:
- Macro: CTRL_DEBOUNCE_EN.
- Defined: each synchronised button feeds a saturating counter of $clog2(DEBOUNCE_CYCLES) bits.
  - The stable level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any sample equal to the stable level resets the counter.
- Undefined: stable level = synchroniser output; no counter logic is synthesised. DEBOUNCE_CYCLES is ignored.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - button index constants BTN_OP1 = 0, BTN_OP2 = 1, BTN_OPC = 2, BTN_CLR = 3;
  - loaded-mask width constant (3);
  - opcode localparams already used by `alu`.
- One sub-module: button_conditioner (per-button synchroniser + optional debounce + edge pulse), instantiated N_PULSADORES times via generate.
- The existing `alu` is instantiated unchanged.

Test Plan:
- Reset then load: press op_1 = 8'sd5, op_2 = 8'sd3, opcode = ADD (0x20), macro off -> o_loaded 3'b001, 3'b011, 3'b111; o_result = 8, o_valid = 1 exactly 4 edges after the last press.
- Hold bit0 high for 50 cycles while switches change 5 -> 9 -> op_1 stays 5; one pulse only; no change until release and re-press.
- Press bit0 and bit1 in the same synchronised cycle, switches = 8'h7F -> op_1/op_2 unchanged, o_error = 1; next single op_2 press clears o_error.
- Macro on, DEBOUNCE_CYCLES = 4: 3-cycle glitch high -> no load; 4-cycle high -> load exactly 4 + 3 edges after pin rise.
- Valid state, press bit3 -> next cycle o_loaded = 0, o_valid = 0, o_result = 0, o_error = 0.
- Assert i_reset mid-debounce with bit2 held through reset deassert -> all outputs 0 during reset; exactly one opcode load after deassert (+ debounce latency).
